// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak state geometry and lane bit-position helpers
package keccak_pkg;

    localparam int STATE_W = 1600;
    localparam int LANE_W  = 64;

    // Lane (x,y) is stored MSB-first, lane (0,0) at the top of the state vector.
    function automatic int high_pos(input int x, input int y);
        return STATE_W - 1 - LANE_W * (5 * y + x);
    endfunction

    function automatic int low_pos(input int x, input int y);
        return high_pos(x, y) - (LANE_W - 1);
    endfunction

endpackage

// File: rtl/squeeze_serializer.sv
// rtl/squeeze_serializer.sv - captures the Keccak state and streams the digest out as WORD-wide words
module squeeze_serializer
    import keccak_pkg::*;
#(
    parameter int OUT_BITS = 512,
    parameter int WORD     = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] state_in,
    input  logic               state_valid,
    output logic               in_ready,
    output logic [WORD-1:0]    out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               overrun
);

    localparam int N  = OUT_BITS / WORD;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        S_IDLE,
        S_SEND
    } fsm_t;

    fsm_t                fsm;
    logic [CW-1:0]       count;
    logic [OUT_BITS-1:0] shreg;
    logic                last_word;

    // Only the digest portion of the state is ever registered.
    generate
        if (OUT_BITS < STATE_W) begin : g_drop
            logic unused_low_bits;
            assign unused_low_bits = ^state_in[STATE_W-OUT_BITS-1:0];
        end
    endgenerate

    assign last_word = (fsm == S_SEND) && (count == CW'(N - 1));
    assign out_last  = last_word;
    assign in_ready  = (fsm == S_IDLE) || (last_word && out_ready);
    assign out_data  = shreg[OUT_BITS-1 -: WORD];

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= S_IDLE;
            count     <= '0;
            shreg     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state_valid && !in_ready) begin
                overrun <= 1'b1;
            end
            case (fsm)
                S_IDLE: begin
                    if (state_valid) begin
                        shreg     <= state_in[STATE_W-1 -: OUT_BITS];
                        count     <= '0;
                        out_valid <= 1'b1;
                        fsm       <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (last_word) begin
                            // A state arriving with the final handshake chains on with no bubble.
                            if (state_valid) begin
                                shreg <= state_in[STATE_W-1 -: OUT_BITS];
                                count <= '0;
                            end else begin
                                out_valid <= 1'b0;
                                fsm       <= S_IDLE;
                            end
                        end else begin
                            shreg <= shreg << WORD;
                            count <= count + CW'(1);
                        end
                    end
                end
                default: begin
                    fsm       <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_squeeze_serializer.sv
// tb/tb_squeeze_serializer.sv - self-checking bench for squeeze_serializer
module tb_squeeze_serializer;

    logic          clk = 1'b0;
    logic          reset;
    logic [1599:0] state_in, state_in2;
    logic          state_valid, out_ready, sv2, rdy2;
    logic          in_ready, out_valid, out_last, overrun;
    logic [63:0]   out_data;
    logic          in_ready2, out_valid2, out_last2, overrun2;
    logic [31:0]   out_data2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    squeeze_serializer dut (
        .clk(clk), .reset(reset), .state_in(state_in), .state_valid(state_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .overrun(overrun)
    );

    squeeze_serializer #(.OUT_BITS(256), .WORD(32)) dut2 (
        .clk(clk), .reset(reset), .state_in(state_in2), .state_valid(sv2),
        .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(rdy2), .out_last(out_last2), .overrun(overrun2)
    );

    typedef struct {
        logic        sv;
        logic        rdy;
        logic        ev;
        logic [63:0] ed;
        logic        el;
        logic        eir;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1599:0] mk_state(input logic [63:0] base);
        logic [1599:0] s;
        s = '0;
        for (int i = 0; i < 25; i++) s[1599 - 64 * i -: 64] = base + 64'(i);
        return s;
    endfunction

    task automatic cyc_in(input logic sv, input logic rdy);
        @(negedge clk);
        state_valid = sv;
        out_ready   = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        state_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [63:0] q[$];
    logic        ovr_m, exp_ir, prev_stall;
    logic [63:0] prev_data;
    int          idx;

    initial begin
        reset = 1'b1; state_valid = 1'b0; out_ready = 1'b0; sv2 = 1'b0; rdy2 = 1'b1;
        state_in = '0; state_in2 = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed single digest, out_ready held high
        tbl[0] = '{1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1};
        for (int k = 1; k <= 8; k++)
            tbl[k] = '{1'b0, 1'b1, 1'b1, 64'(k - 1), (k == 8), (k == 8)};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1};
        state_in = mk_state(0);
        for (int i = 0; i < 10; i++) begin
            cyc_in(tbl[i].sv, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].eir));
            chk($sformatf("tbl%0d_overrun", i), 64'(overrun), 64'd0);
            if (tbl[i].ev || i == 0) begin
                chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
                chk($sformatf("tbl%0d_last", i), 64'(out_last), 64'(tbl[i].el));
            end
        end

        // Backpressure 1,0,0,1,...
        do_reset();
        state_in = mk_state(0);
        cyc_in(1'b1, 1'b1);
        idx = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            logic r;
            r = (c % 4 == 0) || (c % 4 == 3);
            cyc_in(1'b0, r);
            chk("bp_valid", 64'(out_valid), 64'd1);
            if (prev_stall) chk("bp_hold", out_data, prev_data);
            chk("bp_word", out_data, 64'(idx));
            chk("bp_last", 64'(out_last), 64'(idx == 7));
            prev_stall = out_valid && !r;
            prev_data  = out_data;
            if (out_valid && r) idx++;
        end
        chk("bp_count", 64'(idx), 64'd8);
        cyc_in(1'b0, 1'b1);
        chk("bp_done", 64'(out_valid), 64'd0);

        // Back-to-back digests
        do_reset();
        state_in = mk_state(0);
        cyc_in(1'b1, 1'b1);
        for (int k = 0; k < 7; k++) begin
            cyc_in(1'b0, 1'b1);
            chk("b2b_a_word", out_data, 64'(k));
        end
        state_in = mk_state(64'h10);
        cyc_in(1'b1, 1'b1);
        chk("b2b_a_last_data", out_data, 64'd7);
        chk("b2b_a_last", 64'(out_last), 64'd1);
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        cyc_in(1'b0, 1'b1);
        chk("b2b_b_valid", 64'(out_valid), 64'd1);
        chk("b2b_b_first", out_data, 64'h10);
        chk("b2b_overrun", 64'(overrun), 64'd0);
        for (int k = 1; k < 8; k++) begin
            cyc_in(1'b0, 1'b1);
            chk("b2b_b_word", out_data, 64'h10 + 64'(k));
        end
        cyc_in(1'b0, 1'b1);
        chk("b2b_idle", 64'(out_valid), 64'd0);

        // Overrun while word 3 pending
        state_in = mk_state(0);
        cyc_in(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc_in(1'b0, 1'b1);
            chk("ovr_word", out_data, 64'(k));
        end
        state_in = mk_state(64'h40);
        cyc_in(1'b1, 1'b0);
        chk("ovr_in_ready", 64'(in_ready), 64'd0);
        chk("ovr_pending", out_data, 64'd3);
        cyc_in(1'b0, 1'b0);
        chk("ovr_flag", 64'(overrun), 64'd1);
        chk("ovr_hold", out_data, 64'd3);
        for (int k = 3; k < 8; k++) begin
            cyc_in(1'b0, 1'b1);
            chk("ovr_cont", out_data, 64'(k));
        end
        cyc_in(1'b0, 1'b1);
        chk("ovr_idle", 64'(out_valid), 64'd0);
        chk("ovr_sticky", 64'(overrun), 64'd1);

        // Reset mid-stream at word 4
        state_in = mk_state(0);
        cyc_in(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc_in(1'b0, k < 4);
            chk("rst_pre_word", out_data, 64'(k));
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_data", out_data, 64'd0);
        cyc_in(1'b1, 1'b1);
        cyc_in(1'b0, 1'b1);
        chk("rst_restart_valid", 64'(out_valid), 64'd1);
        chk("rst_restart_word", out_data, 64'd0);
        for (int k = 1; k < 9; k++) cyc_in(1'b0, 1'b1);

        // WORD=32, OUT_BITS=256
        state_in2 = mk_state(0);
        @(negedge clk);
        sv2 = 1'b1; rdy2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            sv2 = 1'b0;
            #1;
            chk("w32_valid", 64'(out_valid2), 64'd1);
            chk("w32_word", 64'(out_data2), (k % 2 == 0) ? 64'd0 : 64'(k / 2));
            chk("w32_last", 64'(out_last2), 64'(k == 7));
        end
        @(negedge clk);
        #1;
        chk("w32_idle", 64'(out_valid2), 64'd0);

        // Randomized traffic against a queue-based model
        do_reset();
        q.delete();
        ovr_m = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            out_ready   = ($urandom_range(0, 3) != 0);
            state_valid = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 50; i++) state_in[32 * i +: 32] = $urandom;
            #1;
            exp_ir = (q.size() == 0) || (q.size() == 1 && out_ready);
            chk("rnd_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_data", out_data, q[0]);
                chk("rnd_last", 64'(out_last), 64'(q.size() == 1));
            end
            chk("rnd_in_ready", 64'(in_ready), 64'(exp_ir));
            chk("rnd_overrun", 64'(overrun), 64'(ovr_m));
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (state_valid) begin
                if (exp_ir) begin
                    for (int k = 0; k < 8; k++) q.push_back(state_in[1599 - 64 * k -: 64]);
                end else begin
                    ovr_m = 1'b1;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
